// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, constants and operand classification
// for the FP32 arithmetic leaves.
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

    // Subnormals (exponent field 0) classify as ZERO, flushing them on input.
    function automatic fp_class_e classify(input logic [31:0] x);
        fp_class_e c;
        c = NORMAL;
        if (x[30:23] == '0) begin
            c = ZERO;
        end else if (x[30:23] == '1) begin
            c = (x[22:0] != '0) ? NAN : INF;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp_multiply_32_if.sv
// Operand/result bundle for the FP32 multiplier: issue side drives
// valid_i/A/B, the multiplier returns Result/done_o.
interface fp_multiply_32_if #(
    parameter int DATA_WIDTH = 32
);

    logic                  valid_i;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic [DATA_WIDTH-1:0] Result;
    logic                  done_o;

    modport master (
        output valid_i,
        output A,
        output B,
        input  Result,
        input  done_o
    );

    modport slave (
        input  valid_i,
        input  A,
        input  B,
        output Result,
        output done_o
    );

endinterface

// File: rtl/fp32_round_pack.sv
// Combinational final stage of the FP32 multiplier: normalise the 48-bit
// significand product, round to nearest even, range-check and pack.
import fp32_pkg::*;

module fp32_round_pack (
    input  logic [PROD_W-1:0] i_prod,
    input  logic signed [9:0] i_exp,
    input  logic              i_sign,
    input  fp_class_e         i_cls,
    output logic [31:0]       o_word
);

    // Increment when guard is set and the value is above the halfway point,
    // or exactly at it with an odd lsb.
    function automatic logic [SIG_W:0] round_rne(input logic [SIG_W-1:0] sig,
                                                 input logic g, input logic r,
                                                 input logic s);
        logic inc;
        inc = g & (r | s | sig[0]);
        return {1'b0, sig} + {{SIG_W{1'b0}}, inc};
    endfunction

    function automatic logic [31:0] pack_range(input logic sign,
                                               input logic signed [9:0] exp,
                                               input logic [MAN_W-1:0] man);
        logic [31:0] w;
        if (exp >= 10'sd255) begin
            w = {sign, POS_INF[30:0]};
        end else if (exp <= 10'sd0) begin
            w = {sign, 31'd0};
        end else begin
            w = {sign, exp[EXP_W-1:0], man};
        end
        return w;
    endfunction

    logic                w_msb;
    logic [SIG_W-1:0]    w_sig;
    logic                w_guard;
    logic                w_round;
    logic                w_sticky;
    logic signed [9:0]   w_exp_norm;
    logic [SIG_W:0]      w_rnd;
    logic [MAN_W-1:0]    w_man;
    logic signed [9:0]   w_exp_fin;

    assign w_msb      = i_prod[PROD_W-1];
    assign w_sig      = w_msb ? i_prod[47:24] : i_prod[46:23];
    assign w_guard    = w_msb ? i_prod[23]    : i_prod[22];
    assign w_round    = w_msb ? i_prod[22]    : i_prod[21];
    assign w_sticky   = w_msb ? (|i_prod[21:0]) : (|i_prod[20:0]);
    assign w_exp_norm = w_msb ? (i_exp + 10'sd1) : i_exp;

    assign w_rnd = round_rne(w_sig, w_guard, w_round, w_sticky);

    // A carry out of rounding leaves 10..0, so the upper slice is all zero.
    assign w_man     = w_rnd[SIG_W] ? w_rnd[SIG_W-1:1] : w_rnd[MAN_W-1:0];
    assign w_exp_fin = w_rnd[SIG_W] ? (w_exp_norm + 10'sd1) : w_exp_norm;

    always_comb begin
        o_word = pack_range(i_sign, w_exp_fin, w_man);
        case (i_cls)
            NAN:     o_word = QNAN;
            INF:     o_word = {i_sign, POS_INF[30:0]};
            ZERO:    o_word = {i_sign, 31'd0};
            default: o_word = pack_range(i_sign, w_exp_fin, w_man);
        endcase
    end

endmodule

// File: rtl/fp_multiply_32.sv
// Pipelined binary32 multiplier, round-to-nearest-even, flush-to-zero.
// Operands captured on valid_i; done_o pulses three edges later with Result.
import fp32_pkg::*;

module fp_multiply_32 #(
    parameter int DATA_WIDTH = 32
) (
    input logic               clk_i,
    input logic               rst_i,
    fp_multiply_32_if.slave   bus
);

    localparam logic signed [9:0] BIAS_S = 10'(BIAS);

    logic                  r_vld_p0;
    logic                  r_vld_p1;
    logic                  r_vld_p2;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_result;

    logic [DATA_WIDTH-1:0] r_a_p0;
    logic [DATA_WIDTH-1:0] r_b_p0;

    logic                  r_sign_p1;
    fp_class_e             r_cls_p1;
    logic signed [9:0]     r_exp_p1;
    logic [SIG_W-1:0]      r_sig_a_p1;
    logic [SIG_W-1:0]      r_sig_b_p1;

    logic                  r_sign_p2;
    fp_class_e             r_cls_p2;
    logic signed [9:0]     r_exp_p2;
    logic [PROD_W-1:0]     r_prod_p2;

    fp_class_e             w_cls_a;
    fp_class_e             w_cls_b;
    fp_class_e             w_cls;
    logic signed [9:0]     w_exp_sum;
    logic [31:0]           w_word;

    assign w_cls_a   = classify(r_a_p0);
    assign w_cls_b   = classify(r_b_p0);
    assign w_exp_sum = $signed({2'b00, r_a_p0[30:23]})
                     + $signed({2'b00, r_b_p0[30:23]}) - BIAS_S;

    // Special-case priority: NaN, Inf x 0, Inf, zero, then normal.
    always_comb begin
        w_cls = NORMAL;
        if (w_cls_a == NAN || w_cls_b == NAN) begin
            w_cls = NAN;
        end else if ((w_cls_a == INF && w_cls_b == ZERO) ||
                     (w_cls_a == ZERO && w_cls_b == INF)) begin
            w_cls = NAN;
        end else if (w_cls_a == INF || w_cls_b == INF) begin
            w_cls = INF;
        end else if (w_cls_a == ZERO || w_cls_b == ZERO) begin
            w_cls = ZERO;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_vld_p0 <= bus.valid_i;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
            r_done   <= r_vld_p2;
            if (r_vld_p2) begin
                r_result <= w_word;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // p0: raw operand capture
        if (bus.valid_i) begin
            r_a_p0 <= bus.A;
            r_b_p0 <= bus.B;
        end
        // p1: unpack, classify, sign, exponent sum
        if (r_vld_p0) begin
            r_sign_p1  <= r_a_p0[31] ^ r_b_p0[31];
            r_cls_p1   <= w_cls;
            r_exp_p1   <= w_exp_sum;
            r_sig_a_p1 <= {1'b1, r_a_p0[MAN_W-1:0]};
            r_sig_b_p1 <= {1'b1, r_b_p0[MAN_W-1:0]};
        end
        // p2: 24x24 significand product
        if (r_vld_p1) begin
            r_sign_p2 <= r_sign_p1;
            r_cls_p2  <= r_cls_p1;
            r_exp_p2  <= r_exp_p1;
            r_prod_p2 <= {{SIG_W{1'b0}}, r_sig_a_p1} * {{SIG_W{1'b0}}, r_sig_b_p1};
        end
    end

    // p3: normalise, round, pack into the registered Result
    fp32_round_pack u_round_pack (
        .i_prod (r_prod_p2),
        .i_exp  (r_exp_p2),
        .i_sign (r_sign_p2),
        .i_cls  (r_cls_p2),
        .o_word (w_word)
    );

    assign bus.Result = r_result;
    assign bus.done_o = r_done;

endmodule

// File: tb/tb_fp_multiply_32.sv
// Bench for fp_multiply_32: directed cases plus a random stream checked
// against an exact-integer reference model through a scoreboard queue.
module tb_fp_multiply_32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_multiply_32_if #(.DATA_WIDTH(32)) bus ();

    fp_multiply_32 #(.DATA_WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        int          due;
        string       tag;
    } exp_t;

    exp_t  sb[$];
    int    cyc      = 0;
    int    n_done   = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    string cur_tag  = "reset";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Exact significand product, rounded by comparing the discarded part to one half.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, k, sh, be;
        logic [22:0] ma, mb;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [47:0] p, q, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = a[22:0];
        mb = b[22:0];
        a_nan  = (ea == 255) && (ma != 0);
        b_nan  = (eb == 255) && (mb != 0);
        a_inf  = (ea == 255) && (ma == 0);
        b_inf  = (eb == 255) && (mb == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan) return 32'h7FC00000;
        if ((a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC00000;
        if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {s, 31'd0};
        p = {24'd0, 1'b1, ma} * {24'd0, 1'b1, mb};
        k = 47;
        while (p[k] == 1'b0) k--;
        sh   = k - 23;
        q    = p >> sh;
        rem  = p & ((48'd1 << sh) - 48'd1);
        half = 48'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 48'd1;
        if (q[24]) begin
            q  = q >> 1;
            sh = sh + 1;
        end
        be = sh + ea + eb - 150;
        if (be >= 255) return {s, 8'hFF, 23'd0};
        if (be <= 0) return {s, 31'd0};
        return {s, be[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        int          sel;
        logic [7:0]  e;
        logic [31:0] m;
        sel = $urandom_range(0, 15);
        m   = $urandom();
        case (sel)
            0:       begin e = 8'd0;   if ($urandom_range(0, 1) == 0) m = 0; end
            1:       begin e = 8'hFF;  if ($urandom_range(0, 1) == 0) m = 0; end
            2, 3:    e = 8'($urandom_range(1, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom_range(0, 1)), e, m[22:0]};
    endfunction

    // Issue side of the scoreboard: every accepted operand pair is due 3 edges later.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                sb.delete();
            end else if (bus.valid_i) begin
                sb.push_back('{res: ref_mul(bus.A, bus.B), due: cyc + 3, tag: cur_tag});
            end
            cyc++;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done_o) begin
                n_done++;
                if (sb.size() == 0) begin
                    check("spurious_done", 32'(bus.done_o), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_result"}, bus.Result, e.res);
                    check({e.tag, "_latency"}, 32'(cyc - 1), 32'(e.due));
                end
            end else if (sb.size() > 0 && (cyc - 1) > sb[0].due) begin
                e = sb.pop_front();
                check({e.tag, "_done_missing"}, 32'(bus.done_o), 32'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        bus.valid_i = 1'b1;
        bus.A       = a;
        bus.B       = b;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (sb.size() > 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_drain"}, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] dir_a [10] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'hBFC00000,
                                32'h2317A4DB, 32'h3F800001, 32'h7F800000, 32'h7F000000,
                                32'h00800000, 32'h7FC00001};
    logic [31:0] dir_b [10] = '{32'h00000000, 32'h3F988D00, 32'h40400000, 32'h40000000,
                                32'h00000000, 32'h3F800001, 32'h00000000, 32'h7F000000,
                                32'h00800000, 32'h3F800000};
    logic [31:0] dir_r [10] = '{32'h00000000, 32'h3F988D00, 32'h40C00000, 32'hC0400000,
                                32'h00000000, 32'h3F800002, 32'h7FC00000, 32'h7F800000,
                                32'h00000000, 32'h7FC00000};

    initial begin
        int d0;
        bus.valid_i = 1'b0;
        bus.A       = '0;
        bus.B       = '0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", bus.Result, 32'h00000000);
        check("rst_done", 32'(bus.done_o), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cur_tag = $sformatf("dir%0d", i);
            check({cur_tag, "_model"}, ref_mul(dir_a[i], dir_b[i]), dir_r[i]);
            issue(dir_a[i], dir_b[i]);
            drain(cur_tag);
        end

        // Three consecutive issues: 2*3, 1*1, -1.5*2
        cur_tag = "b2b";
        bus.valid_i = 1'b1;
        bus.A = 32'h40000000; bus.B = 32'h40400000;
        @(posedge clk); #1;
        bus.A = 32'h3F800000; bus.B = 32'h3F800000;
        @(posedge clk); #1;
        bus.A = 32'hBFC00000; bus.B = 32'h40000000;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        d0 = n_done;
        drain("b2b");
        check("b2b_count", 32'(n_done - d0), 32'd3);

        cur_tag = "midrst";
        issue(32'h3F800000, 32'h40000000);
        @(posedge clk); #1;
        rst = 1'b1;
        d0  = n_done;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_dones", 32'(n_done - d0), 32'd0);
        check("midrst_result", bus.Result, 32'h00000000);

        cur_tag = "rand";
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                bus.valid_i = 1'b1;
                bus.A       = rand_fp();
                bus.B       = rand_fp();
            end else begin
                bus.valid_i = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        bus.valid_i = 1'b0;
        drain("rand");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
